acc_seq_ctrl: RTL and testbench

//  Job sequencer for the matrix-vector accelerator: one start pulse runs A-load, X-load,
//  NUM_ROWS ALU issues, then waits for all write-backs and reports done.

---
 rtl/acc_pkg.sv | 21 ++
 rtl/acc_seq_ctrl_if.sv | 40 ++++
 rtl/acc_seq_wdog.sv | 33 +++
 rtl/acc_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_acc_seq_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// acc_pkg: shared definitions for the accelerator job sequencer.
//   state_t          - 3-bit FSM state encoding (IDLE..DONE)
//   NUM_ROWS_DEF     - default rows issued per job
//   ROW_W_DEF        - default row index width
//   WDOG_CYCLES_DEF  - default watchdog limit per wait state
package acc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_X = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int unsigned NUM_ROWS_DEF    = 4;
    localparam int unsigned ROW_W_DEF       = 2;
    localparam int unsigned WDOG_CYCLES_DEF = 255;

endpackage

// File: rtl/acc_seq_ctrl_if.sv
// acc_seq_ctrl_if: control bundle between the APB decode / buffers / ALU / wb
// and the job sequencer.
//   inputs to sequencer : start_i, abort_i, load_a_done_i, load_x_done_i, web_i
//   outputs of sequencer: load_a_en_o, load_x_en_o, alu_en_o, row_count_o,
//                         row_finish_o, busy_o, done_o, err_o
//   modport slave  - the sequencer side
//   modport master - the surrounding datapath / decode side
interface acc_seq_ctrl_if
    import acc_pkg::*;
#(
    parameter int unsigned ROW_W = ROW_W_DEF
) ();

    logic             start_i;
    logic             abort_i;
    logic             load_a_done_i;
    logic             load_x_done_i;
    logic             web_i;
    logic             load_a_en_o;
    logic             load_x_en_o;
    logic             alu_en_o;
    logic [ROW_W-1:0] row_count_o;
    logic             row_finish_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    modport slave (
        input  start_i, abort_i, load_a_done_i, load_x_done_i, web_i,
        output load_a_en_o, load_x_en_o, alu_en_o, row_count_o,
               row_finish_o, busy_o, done_o, err_o
    );

    modport master (
        output start_i, abort_i, load_a_done_i, load_x_done_i, web_i,
        input  load_a_en_o, load_x_en_o, alu_en_o, row_count_o,
               row_finish_o, busy_o, done_o, err_o
    );

endinterface

// File: rtl/acc_seq_wdog.sv
// acc_seq_wdog: timeout counter for the sequencer wait states.
//   clk    - gated accelerator clock
//   rst    - synchronous reset, active-high
//   clear  - restart the count (wait-state entry)
//   run    - count this cycle (sequencer is in a wait state)
//   expire - this is the LIMIT-th consecutive running cycle since clear
module acc_seq_wdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int unsigned CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (run && cnt != LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Independent of clear so the sequencer's next-state logic has no loop.
    assign expire = run && (cnt == LAST);

endmodule

// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: matrix-vector job sequencer (A-load, X-load, NUM_ROWS ALU
// issues, wait for all write-backs, done pulse). All outputs registered.
//   clk  - gated accelerator clock
//   rst  - synchronous reset, active-high
//   bus  - acc_seq_ctrl_if.slave: start/abort/done/web in, enables/status out
// Optional watchdog on LOAD_A/LOAD_X/DRAIN: define ACC_SEQ_WDOG_EN.
module acc_seq_ctrl
    import acc_pkg::*;
#(
    parameter int unsigned NUM_ROWS    = NUM_ROWS_DEF,
    parameter int unsigned ROW_W       = ROW_W_DEF,
    parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    acc_seq_ctrl_if.slave bus
);

    if (NUM_ROWS < 2 || (1 << ROW_W) < NUM_ROWS || WDOG_CYCLES < 1) begin : g_param_check
        $error("acc_seq_ctrl: invalid NUM_ROWS/ROW_W/WDOG_CYCLES");
    end

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
    localparam logic [ROW_W:0]   RES_FULL = (ROW_W + 1)'(NUM_ROWS);

    state_t           state, state_nx;
    logic [ROW_W-1:0] row, row_nx;
    logic [ROW_W:0]   res, res_nx;
    logic             err, err_nx;
    logic             wdog_expire;

    logic load_a_en, load_x_en, alu_en, row_finish, busy, done;

`ifdef ACC_SEQ_WDOG_EN
    logic in_wait, in_wait_nx, wdog_clear;

    assign in_wait    = state    inside {ST_LOAD_A, ST_LOAD_X, ST_DRAIN};
    assign in_wait_nx = state_nx inside {ST_LOAD_A, ST_LOAD_X, ST_DRAIN};
    assign wdog_clear = in_wait_nx && (state_nx != state);

    acc_seq_wdog #(.LIMIT(WDOG_CYCLES)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wdog_clear),
        .run    (in_wait),
        .expire (wdog_expire)
    );
`else
    assign wdog_expire = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        row_nx   = row;
        res_nx   = res;
        err_nx   = err;
        if (bus.abort_i) begin
            state_nx = ST_IDLE;
        end else begin
            // Result counter saturates; a strobe on the last ISSUE cycle is
            // already seen as ISSUE here, so the DRAIN-entry pulse counts.
            if ((state == ST_ISSUE || state == ST_DRAIN) && bus.web_i && res != RES_FULL) begin
                res_nx = res + (ROW_W + 1)'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        state_nx = ST_LOAD_A;
                        row_nx   = '0;
                        res_nx   = '0;
                        err_nx   = 1'b0;
                    end
                end
                ST_LOAD_A: begin
                    if (wdog_expire) begin
                        state_nx = ST_IDLE;
                        err_nx   = 1'b1;
                    end else if (bus.load_a_done_i) begin
                        state_nx = ST_LOAD_X;
                    end
                end
                ST_LOAD_X: begin
                    if (wdog_expire) begin
                        state_nx = ST_IDLE;
                        err_nx   = 1'b1;
                    end else if (bus.load_x_done_i) begin
                        state_nx = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (row == ROW_LAST) begin
                        state_nx = ST_DRAIN;
                    end else begin
                        row_nx = row + ROW_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (wdog_expire) begin
                        state_nx = ST_IDLE;
                        err_nx   = 1'b1;
                    end else if (res_nx == RES_FULL) begin
                        state_nx = ST_DONE;
                    end
                end
                ST_DONE: state_nx = ST_IDLE;
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            row        <= '0;
            res        <= '0;
            err        <= 1'b0;
            load_a_en  <= 1'b0;
            load_x_en  <= 1'b0;
            alu_en     <= 1'b0;
            row_finish <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            row        <= row_nx;
            res        <= res_nx;
            err        <= err_nx;
            load_a_en  <= (state_nx == ST_LOAD_A);
            load_x_en  <= (state_nx == ST_LOAD_X);
            alu_en     <= (state_nx == ST_ISSUE);
            row_finish <= (state_nx == ST_ISSUE) && (row_nx == ROW_LAST);
            busy       <= (state_nx != ST_IDLE);
            done       <= (state_nx == ST_DONE);
        end
    end

    assign bus.load_a_en_o  = load_a_en;
    assign bus.load_x_en_o  = load_x_en;
    assign bus.alu_en_o     = alu_en;
    assign bus.row_count_o  = row;
    assign bus.row_finish_o = row_finish;
    assign bus.busy_o       = busy;
    assign bus.done_o       = done;
    assign bus.err_o        = err;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// tb_acc_seq_ctrl: self-checking bench for acc_seq_ctrl.
// Jobs are described as a timeline (start at cycle 0, load_a_done at a,
// load_x_done at x, write-back strobes, optional abort at b); expected
// outputs per cycle are derived arithmetically from that timeline.
// Define ACC_SEQ_WDOG_EN to also exercise the watchdog (limit 16).
module tb_acc_seq_ctrl;

    localparam int NR   = 4;
    localparam int RW   = 2;
    localparam int MAXC = 64;
`ifdef ACC_SEQ_WDOG_EN
    localparam int WDOG = 16;
`else
    localparam int WDOG = 255;
`endif

    logic clk = 1'b0;
    logic rst;

    acc_seq_ctrl_if #(.ROW_W(RW)) bus ();

    acc_seq_ctrl #(.NUM_ROWS(NR), .ROW_W(RW), .WDOG_CYCLES(WDOG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit web_at   [MAXC];
    bit start_at [MAXC];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string ph, input int k,
                             input bit e_busy, input bit e_la, input bit e_lx,
                             input bit e_alu, input bit e_fin, input bit e_done,
                             input bit e_err, input int e_row);
        check_eq($sformatf("%s.busy@%0d", ph, k),   32'(bus.busy_o),       32'(e_busy));
        check_eq($sformatf("%s.la_en@%0d", ph, k),  32'(bus.load_a_en_o),  32'(e_la));
        check_eq($sformatf("%s.lx_en@%0d", ph, k),  32'(bus.load_x_en_o),  32'(e_lx));
        check_eq($sformatf("%s.alu_en@%0d", ph, k), 32'(bus.alu_en_o),     32'(e_alu));
        check_eq($sformatf("%s.finish@%0d", ph, k), 32'(bus.row_finish_o), 32'(e_fin));
        check_eq($sformatf("%s.done@%0d", ph, k),   32'(bus.done_o),       32'(e_done));
        check_eq($sformatf("%s.err@%0d", ph, k),    32'(bus.err_o),        32'(e_err));
        if (e_alu)
            check_eq($sformatf("%s.row@%0d", ph, k), 32'(bus.row_count_o), 32'(e_row));
    endtask

    task automatic drive_idle();
        bus.start_i       = 1'b0;
        bus.abort_i       = 1'b0;
        bus.load_a_done_i = 1'b0;
        bus.load_x_done_i = 1'b0;
        bus.web_i         = 1'b0;
    endtask

    task automatic clear_stim();
        for (int k = 0; k < MAXC; k++) begin
            web_at[k]   = 1'b0;
            start_at[k] = 1'b0;
        end
    endtask

    // Cycle of the done pulse: the NR-th strobe counted (strobes at cycle k
    // count once ISSUE began, k >= x+1), but never before one DRAIN cycle.
    function automatic int done_cycle(input int x);
        int cnt = 0;
        int w = MAXC;
        for (int k = x + 1; k < MAXC; k++) begin
            if (web_at[k] && cnt < NR) begin
                cnt++;
                if (cnt == NR) w = k;
            end
        end
        return (w > x + NR + 1) ? w : x + NR + 1;
    endfunction

    task automatic run_job(input string ph, input int a, input int x, input int b, input bit ldx_early);
        int d, last, stop;
        bit live;
        d = done_cycle(x);
        last = 0;
        for (int k = 0; k < MAXC; k++) if (web_at[k]) last = k;
        stop = ((d > last) ? d : last) + 2;
        for (int k = 0; k <= stop; k++) begin
            bus.start_i       = (k == 0) || start_at[k];
            bus.abort_i       = (k == b);
            bus.load_a_done_i = (k == a);
            bus.load_x_done_i = (k == x) || (ldx_early && k == a);
            bus.web_i         = web_at[k];
            @(posedge clk);
            #1;
            live = (b < 0) || (k < b);
            check_all(ph, k, live && k <= d, live && k < a, live && k >= a && k < x,
                      live && k >= x && k < x + NR, live && k == x + NR - 1,
                      live && k == d, 1'b0, k - x);
        end
        drive_idle();
    endtask

    task automatic random_job(input string ph, input bit do_abort);
        int a, x, n, cnt, s, d, b, lim;
        clear_stim();
        a = int'($urandom_range(1, 5));
        x = a + int'($urandom_range(1, 5));
        n = NR + int'($urandom_range(0, 2));
        cnt = 0;
        while (cnt < n) begin
            s = x + 1 + int'($urandom_range(0, NR + 5));
            if (!web_at[s]) begin
                web_at[s] = 1'b1;
                cnt++;
            end
        end
        if ($urandom_range(0, 1) == 1) web_at[$urandom_range(1, x)] = 1'b1;
        d   = done_cycle(x);
        b   = do_abort ? int'($urandom_range(1, d)) : -1;
        lim = do_abort ? b : d;
        for (int i = 0; i < 2; i++) start_at[$urandom_range(1, lim)] = 1'b1;
        run_job(ph, a, x, b, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("reset.row", 32'(bus.row_count_o), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic job: load_a_done at 3, load_x_done at 6, four write-backs.
        clear_stim();
        for (int k = 7; k <= 10; k++) web_at[k] = 1'b1;
        run_job("basic", 3, 6, -1, 1'b0);

        // start_i during LOAD_X and ISSUE is ignored.
        clear_stim();
        for (int k = 7; k <= 10; k++) web_at[k] = 1'b1;
        start_at[4] = 1'b1;
        start_at[7] = 1'b1;
        run_job("restart", 3, 6, -1, 1'b0);

        // Abort seen during the second ISSUE cycle, then a clean job.
        clear_stim();
        for (int k = 5; k <= 8; k++) web_at[k] = 1'b1;
        run_job("abort", 2, 4, 6, 1'b0);
        clear_stim();
        for (int k = 5; k <= 8; k++) web_at[k] = 1'b1;
        run_job("after_abort", 2, 4, -1, 1'b0);

        // Six strobes all in DRAIN; done after the fourth, extras ignored.
        clear_stim();
        for (int k = 9; k <= 14; k++) web_at[k] = 1'b1;
        run_job("drain6", 1, 4, -1, 1'b1);

        for (int j = 0; j < 40; j++)
            random_job($sformatf("rnd%0d", j), ($urandom_range(0, 3) == 0));

`ifdef ACC_SEQ_WDOG_EN
        // load_x_done never arrives: 16 LOAD_X cycles, then error and IDLE.
        for (int k = 0; k <= 20; k++) begin
            bus.start_i       = (k == 0);
            bus.load_a_done_i = (k == 2);
            @(posedge clk);
            #1;
            check_all("wdog", k, k <= 17, k < 2, k >= 2 && k <= 17, 0, 0, 0, k >= 18, 0);
        end
        drive_idle();
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        check_eq("wdog.err_cleared", 32'(bus.err_o), 32'd0);
        check_eq("wdog.restart_busy", 32'(bus.busy_o), 32'd1);
        bus.abort_i = 1'b1;
        @(posedge clk);
        #1;
        bus.abort_i = 1'b0;
        check_eq("wdog.abort_idle", 32'(bus.busy_o), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
